// File: rtl/riscv_mem_req_arb3_if.sv
// Request/response bundle shared by the three requesters, the arbiter and the
// memory.
//
// Ports of the bundle:
//   req{0,1,2}_msg/val   requester -> arbiter  request message and valid
//   req{0,1,2}_rdy       arbiter -> requester  request accepted this cycle
//   resp{0,1,2}_msg/val  arbiter -> requester  steered memory response
//   memreq_msg/val       arbiter -> memory     merged request
//   memreq_rdy           memory -> arbiter     memory accepts request
//   memresp_msg/val      memory -> arbiter     in-order response, never stalled
//
// Modports:
//   slave   the arbiter's view of the bundle
//   master  the environment's view (requesters and memory together)
interface riscv_mem_req_arb3_if #(
  parameter int REQ_W  = 67,
  parameter int RESP_W = 35
);
  logic [REQ_W-1:0]  req0_msg;
  logic              req0_val;
  logic              req0_rdy;
  logic [REQ_W-1:0]  req1_msg;
  logic              req1_val;
  logic              req1_rdy;
  logic [REQ_W-1:0]  req2_msg;
  logic              req2_val;
  logic              req2_rdy;

  logic [RESP_W-1:0] resp0_msg;
  logic              resp0_val;
  logic [RESP_W-1:0] resp1_msg;
  logic              resp1_val;
  logic [RESP_W-1:0] resp2_msg;
  logic              resp2_val;

  logic [REQ_W-1:0]  memreq_msg;
  logic              memreq_val;
  logic              memreq_rdy;
  logic [RESP_W-1:0] memresp_msg;
  logic              memresp_val;

  modport slave (
    input  req0_msg, req0_val, req1_msg, req1_val, req2_msg, req2_val,
    input  memreq_rdy, memresp_msg, memresp_val,
    output req0_rdy, req1_rdy, req2_rdy,
    output resp0_msg, resp0_val, resp1_msg, resp1_val, resp2_msg, resp2_val,
    output memreq_msg, memreq_val
  );

  modport master (
    output req0_msg, req0_val, req1_msg, req1_val, req2_msg, req2_val,
    output memreq_rdy, memresp_msg, memresp_val,
    input  req0_rdy, req1_rdy, req2_rdy,
    input  resp0_msg, resp0_val, resp1_msg, resp1_val, resp2_msg, resp2_val,
    input  memreq_msg, memreq_val
  );
endinterface

// File: rtl/riscv_mem_req_arb3.sv
// Three-way round-robin arbiter in front of one single-ported memory channel.
// Requests pass straight through combinationally; the ID of every accepted
// request is queued so the in-order memory responses can be steered back to
// the port that issued them.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          request/response bundle (slave modport)
//   outstanding  current ID FIFO occupancy
//   err_orphan   sticky flag: a response arrived with no request outstanding
module riscv_mem_req_arb3 #(
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  riscv_mem_req_arb3_if.slave        bus,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       err_orphan
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  function automatic logic [1:0] f_next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  logic [1:0]    r_rr_ptr;
  logic          r_lock;
  logic [1:0]    r_held_id;
  logic [1:0]    r_ids [MAX_OUT];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_orphan;

  logic [2:0]    w_val;
  logic          w_any;
  logic [1:0]    w_grant;
  logic          w_full;
  logic          w_empty;
  logic          w_memreq_val;
  logic          w_fire;
  logic          w_pop;
  logic [1:0]    w_head;

  assign w_val   = {bus.req2_val, bus.req1_val, bus.req0_val};
  assign w_any   = |w_val;
  assign w_full  = (r_count == CW'(MAX_OUT));
  assign w_empty = (r_count == '0);
  assign w_head  = r_ids[r_rd_ptr];

  // Scan order starts at r_rr_ptr; a stalled request keeps its grant via the
  // lock so the message seen by memory cannot change before it is accepted.
  always_comb begin
    w_grant = r_rr_ptr;
    if (r_lock) begin
      w_grant = r_held_id;
    end else begin
      case (r_rr_ptr)
        2'd1: begin
          if      (w_val[1]) w_grant = 2'd1;
          else if (w_val[2]) w_grant = 2'd2;
          else if (w_val[0]) w_grant = 2'd0;
        end
        2'd2: begin
          if      (w_val[2]) w_grant = 2'd2;
          else if (w_val[0]) w_grant = 2'd0;
          else if (w_val[1]) w_grant = 2'd1;
        end
        default: begin
          if      (w_val[0]) w_grant = 2'd0;
          else if (w_val[1]) w_grant = 2'd1;
          else if (w_val[2]) w_grant = 2'd2;
        end
      endcase
    end
  end

  // A full FIFO blocks grants even when a pop happens the same cycle; this
  // keeps the full decision purely registered.
  assign w_memreq_val = w_any & ~w_full;
  assign w_fire       = w_memreq_val & bus.memreq_rdy;
  assign w_pop        = bus.memresp_val & ~w_empty;

  always_comb begin
    case (w_grant)
      2'd1:    bus.memreq_msg = bus.req1_msg;
      2'd2:    bus.memreq_msg = bus.req2_msg;
      default: bus.memreq_msg = bus.req0_msg;
    endcase
  end

  // Handshake outputs are qualified by reset so nothing fires while the
  // block is held in reset.
  assign bus.memreq_val = reset & w_memreq_val;
  assign bus.req0_rdy   = reset & (w_grant == 2'd0) & bus.memreq_rdy & ~w_full;
  assign bus.req1_rdy   = reset & (w_grant == 2'd1) & bus.memreq_rdy & ~w_full;
  assign bus.req2_rdy   = reset & (w_grant == 2'd2) & bus.memreq_rdy & ~w_full;

  assign bus.resp0_val  = reset & w_pop & (w_head == 2'd0);
  assign bus.resp1_val  = reset & w_pop & (w_head == 2'd1);
  assign bus.resp2_val  = reset & w_pop & (w_head == 2'd2);
  assign bus.resp0_msg  = bus.memresp_msg;
  assign bus.resp1_msg  = bus.memresp_msg;
  assign bus.resp2_msg  = bus.memresp_msg;

  assign outstanding = r_count;
  assign err_orphan  = r_err_orphan;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= 2'd0;
      r_lock       <= 1'b0;
      r_held_id    <= 2'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_memreq_val && !bus.memreq_rdy) begin
        r_lock    <= 1'b1;
        r_held_id <= w_grant;
      end else begin
        r_lock    <= 1'b0;
      end

      if (w_fire) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rr_ptr <= f_next_id(w_grant);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end

      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (bus.memresp_val && w_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_ids[r_wr_ptr] <= w_grant;
    end
  end

endmodule

// File: tb/tb_riscv_mem_req_arb3.sv
module tb_riscv_mem_req_arb3;

  localparam int REQ_W   = 67;
  localparam int RESP_W  = 35;
  localparam int MAX_OUT = 4;

  logic       clk;
  logic       reset;
  logic [2:0] outstanding;
  logic       err_orphan;

  int n_chk;
  int n_err;

  riscv_mem_req_arb3_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) bus ();

  riscv_mem_req_arb3 #(.MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [2:0] w_rdy = {bus.req2_rdy, bus.req1_rdy, bus.req0_rdy};
  wire [2:0] w_rsp = {bus.resp2_val, bus.resp1_val, bus.resp0_val};

  function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] addr);
    return {1'b0, addr, 2'b10, ~addr};
  endfunction

  task automatic check_val(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge. Check point: the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_val(input logic [2:0] v);
    bus.req0_val = v[0];
    bus.req1_val = v[1];
    bus.req2_val = v[2];
  endtask

  logic [REQ_W-1:0] msg [3];
  int               rr_exp [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    msg[0] = mk_req(32'h0000_0000);
    msg[1] = mk_req(32'h0000_0040);
    msg[2] = mk_req(32'h0000_0100);
    bus.req0_msg    = msg[0];
    bus.req1_msg    = msg[1];
    bus.req2_msg    = msg[2];
    bus.memresp_msg = '0;
    bus.memresp_val = 1'b0;
    bus.memreq_rdy  = 1'b1;
    set_val(3'b100);
    reset = 1'b0;
    #1;

    // reset: handshake outputs forced low even with valid inputs
    mid();
    check_val("rst_rdy", w_rdy, 3'b000);
    check_val("rst_memreq_val", bus.memreq_val, 1'b0);
    check_val("rst_outstanding", outstanding, 3'd0);
    check_val("rst_err_orphan", err_orphan, 1'b0);
    adv();
    set_val(3'b000);
    reset = 1'b1;

    // single dmem request, response next cycle
    adv();
    set_val(3'b100);
    mid();
    check_val("single_rdy", w_rdy, 3'b100);
    check_val("single_memreq_val", bus.memreq_val, 1'b1);
    check_val("single_msg", bus.memreq_msg, msg[2]);
    adv();
    set_val(3'b000);
    bus.memresp_val = 1'b1;
    bus.memresp_msg = 35'h5_1234_5678;
    mid();
    check_val("single_outstanding", outstanding, 3'd1);
    check_val("single_resp", w_rsp, 3'b100);
    check_val("single_resp_msg", bus.resp2_msg, 35'h5_1234_5678);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("single_drain", outstanding, 3'd0);

    // round-robin: all ports valid, one response per cycle after the first
    rr_exp = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 6; k++) begin
      adv();
      set_val(3'b111);
      bus.memresp_val = (k > 0);
      mid();
      check_val($sformatf("rr_rdy%0d", k), w_rdy, 3'b001 << rr_exp[k]);
      check_val($sformatf("rr_msg%0d", k), bus.memreq_msg, msg[rr_exp[k]]);
      if (k > 0)
        check_val($sformatf("rr_resp%0d", k), w_rsp, 3'b001 << rr_exp[k-1]);
    end
    adv();
    set_val(3'b000);
    bus.memresp_val = 1'b1;
    mid();
    check_val("rr_last_resp", w_rsp, 3'b100);
    check_val("rr_idle_memreq_val", bus.memreq_val, 1'b0);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("rr_drain", outstanding, 3'd0);

    // lock: req1 stalls three cycles while req0 appears
    adv();
    set_val(3'b010);
    bus.memreq_rdy = 1'b0;
    mid();
    check_val("lock_a_msg", bus.memreq_msg, msg[1]);
    check_val("lock_a_rdy", w_rdy, 3'b000);
    adv();
    set_val(3'b011);
    mid();
    check_val("lock_b_msg", bus.memreq_msg, msg[1]);
    adv();
    mid();
    check_val("lock_c_msg", bus.memreq_msg, msg[1]);
    adv();
    bus.memreq_rdy = 1'b1;
    mid();
    check_val("lock_fire1_rdy", w_rdy, 3'b010);
    check_val("lock_fire1_msg", bus.memreq_msg, msg[1]);
    adv();
    set_val(3'b001);
    mid();
    check_val("lock_fire0_rdy", w_rdy, 3'b001);
    adv();
    set_val(3'b000);
    bus.memresp_val = 1'b1;
    mid();
    check_val("lock_outstanding", outstanding, 3'd2);
    check_val("lock_resp1", w_rsp, 3'b010);
    adv();
    mid();
    check_val("lock_resp0", w_rsp, 3'b001);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("lock_drain", outstanding, 3'd0);

    // full: four fires with no responses, fifth blocked even with a pop
    for (int k = 0; k < 4; k++) begin
      adv();
      set_val(3'b001);
      mid();
      check_val($sformatf("full_fill%0d", k), bus.req0_rdy, 1'b1);
    end
    adv();
    bus.memresp_val = 1'b1;
    mid();
    check_val("full_outstanding", outstanding, 3'd4);
    check_val("full_blocked_rdy", bus.req0_rdy, 1'b0);
    check_val("full_blocked_val", bus.memreq_val, 1'b0);
    check_val("full_pop_resp", w_rsp, 3'b001);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("full_after_pop", outstanding, 3'd3);
    check_val("full_resume_rdy", bus.req0_rdy, 1'b1);
    adv();
    set_val(3'b000);
    bus.memresp_val = 1'b1;
    mid();
    check_val("full_refilled", outstanding, 3'd4);
    for (int k = 0; k < 3; k++) begin
      adv();
      mid();
      check_val($sformatf("full_drain_resp%0d", k), w_rsp, 3'b001);
    end
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("full_drain", outstanding, 3'd0);

    // ordering: issue 0, 2, 1 then return responses in order
    adv(); set_val(3'b001); mid(); check_val("ord_issue0", w_rdy, 3'b001);
    adv(); set_val(3'b100); mid(); check_val("ord_issue2", w_rdy, 3'b100);
    adv(); set_val(3'b010); mid(); check_val("ord_issue1", w_rdy, 3'b010);
    adv();
    set_val(3'b000);
    bus.memresp_val = 1'b1;
    mid(); check_val("ord_resp_a", w_rsp, 3'b001);
    adv(); mid(); check_val("ord_resp_b", w_rsp, 3'b100);
    adv(); mid(); check_val("ord_resp_c", w_rsp, 3'b010);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("ord_drain", outstanding, 3'd0);

    // orphan response with empty FIFO
    adv();
    bus.memresp_val = 1'b1;
    mid();
    check_val("orphan_resp", w_rsp, 3'b000);
    adv();
    bus.memresp_val = 1'b0;
    mid();
    check_val("orphan_flag", err_orphan, 1'b1);
    check_val("orphan_outstanding", outstanding, 3'd0);

    // reset with three outstanding
    for (int k = 0; k < 3; k++) begin
      adv();
      set_val(3'b001);
    end
    adv();
    mid();
    check_val("prerst_outstanding", outstanding, 3'd3);
    adv();
    reset = 1'b0;
    mid();
    check_val("midrst_outstanding", outstanding, 3'd0);
    check_val("midrst_err_orphan", err_orphan, 1'b0);
    check_val("midrst_rdy", w_rdy, 3'b000);
    check_val("midrst_memreq_val", bus.memreq_val, 1'b0);
    adv();
    set_val(3'b000);
    reset = 1'b1;
    adv();
    mid();
    check_val("postrst_outstanding", outstanding, 3'd0);
    check_val("postrst_err_orphan", err_orphan, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
